ex_mem_stage: RTL

Execute-to-memory boundary of the five-stage MIPS pipeline. It computes the ALU forwarding selects (`forwardA`/`forwardB`) from the current EX/MEM and MEM/WB destinations, and forwards store data. It resolves the destination register, detects load-use hazards, and holds the EX/MEM pipeline register that feeds the data-memory stage and the ALU bypass path.

---
 rtl/ex_mem_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary of the five-stage MIPS pipeline: operand forwarding selects,
// store-data forwarding, load-use detection and the EX/MEM pipeline register.
module ex_mem_stage #(
  parameter int REG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] alu_result,
  input  logic             zero,
  input  logic [REG_W-1:0] rt_data_idex,
  input  logic [4:0]       rs_idex,
  input  logic [4:0]       rt_idex,
  input  logic [4:0]       rd_idex,
  input  logic             reg_dst_idex,
  input  logic             reg_write_idex,
  input  logic             mem_read_idex,
  input  logic             mem_write_idex,
  input  logic             mem_to_reg_idex,
  input  logic [4:0]       rs_ifid,
  input  logic [4:0]       rt_ifid,
  input  logic [4:0]       write_reg_memwb,
  input  logic             reg_write_memwb,
  input  logic [REG_W-1:0] data_towrite_memwb,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             load_use_stall,
  output logic [REG_W-1:0] alu_result_exmem,
  output logic [REG_W-1:0] store_data_exmem,
  output logic             zero_exmem,
  output logic [4:0]       write_reg_exmem,
  output logic             reg_write_exmem,
  output logic             mem_read_exmem,
  output logic             mem_write_exmem,
  output logic             mem_to_reg_exmem,
  output logic             valid_exmem
);

  logic [REG_W-1:0] r_alu_result;
  logic [REG_W-1:0] r_store_data;
  logic             r_zero;
  logic [4:0]       r_write_reg;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_mem_to_reg;
  logic             r_valid;

  logic [4:0]       w_write_reg_ex;
  logic [REG_W-1:0] w_store_data;
  logic             w_exmem_fwd_en;

  // EX/MEM beats MEM/WB; register 0 never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src_reg,
    input logic       ex_en,
    input logic [4:0] ex_reg,
    input logic       wb_en,
    input logic [4:0] wb_reg
  );
    logic [1:0] sel;
    if (ex_en && (ex_reg != 5'd0) && (ex_reg == src_reg)) begin
      sel = 2'b10;
    end else if (wb_en && (wb_reg != 5'd0) && (wb_reg == src_reg)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Destination resolution, forwarding selects and load-use detection
  always_comb begin
    w_write_reg_ex = reg_dst_idex ? rd_idex : rt_idex;
    w_exmem_fwd_en = r_reg_write & r_valid;
    forwardA = fwd_sel(rs_idex, w_exmem_fwd_en, r_write_reg,
                       reg_write_memwb, write_reg_memwb);
    forwardB = fwd_sel(rt_idex, w_exmem_fwd_en, r_write_reg,
                       reg_write_memwb, write_reg_memwb);
    load_use_stall = mem_read_idex & (w_write_reg_ex != 5'd0) &
                     ((w_write_reg_ex == rs_ifid) | (w_write_reg_ex == rt_ifid));
  end

  // Store data follows the rt forwarding select, not the ALU immediate mux
  always_comb begin
    w_store_data = rt_data_idex;
    case (forwardB)
      2'b10:   w_store_data = r_alu_result;
      2'b01:   w_store_data = data_towrite_memwb;
      default: w_store_data = rt_data_idex;
    endcase
  end

  // EX/MEM pipeline register: flush beats stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_zero       <= 1'b0;
      r_write_reg  <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_valid      <= 1'b0;
    end else if (flush) begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_zero       <= 1'b0;
      r_write_reg  <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_valid      <= 1'b0;
    end else if (stall) begin
      r_alu_result <= r_alu_result;
      r_store_data <= r_store_data;
      r_zero       <= r_zero;
      r_write_reg  <= r_write_reg;
      r_reg_write  <= r_reg_write;
      r_mem_read   <= r_mem_read;
      r_mem_write  <= r_mem_write;
      r_mem_to_reg <= r_mem_to_reg;
      r_valid      <= r_valid;
    end else begin
      r_alu_result <= alu_result;
      r_store_data <= w_store_data;
      r_zero       <= zero;
      r_write_reg  <= w_write_reg_ex;
      r_reg_write  <= reg_write_idex;
      r_mem_read   <= mem_read_idex;
      r_mem_write  <= mem_write_idex;
      r_mem_to_reg <= mem_to_reg_idex;
      r_valid      <= 1'b1;
    end
  end

  assign alu_result_exmem = r_alu_result;
  assign store_data_exmem = r_store_data;
  assign zero_exmem       = r_zero;
  assign write_reg_exmem  = r_write_reg;
  assign reg_write_exmem  = r_reg_write;
  assign mem_read_exmem   = r_mem_read;
  assign mem_write_exmem  = r_mem_write;
  assign mem_to_reg_exmem = r_mem_to_reg;
  assign valid_exmem      = r_valid;

endmodule
